// File: rtl/col_drain_buf.sv
// Double-buffered per-column result drain: rows are captured in any order into
// two banks and presented strictly in row order over a valid/ready handshake.
module col_drain_buf #(
    parameter  int ROWS     = 8,
    parameter  int OUTWIDTH = 32,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(2*ROWS+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OUTWIDTH-1:0] in_r [0:ROWS-1],
    input  logic [ROWS-1:0]     in_v,
    output logic [OUTWIDTH-1:0] out_r,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RW-1:0]       out_row,
    output logic                tile_done,
    output logic [CW-1:0]       occupancy,
    output logic                err_ovf
);

    localparam logic [RW-1:0] LAST = RW'(ROWS-1);

    logic [OUTWIDTH-1:0]      mem [0:1][0:ROWS-1];
    logic [1:0][ROWS-1:0]     full;
    logic [ROWS-1:0]          wsel;
    logic                     rsel;
    logic [RW-1:0]            rptr;

    logic [ROWS-1:0]          wr_ok;
    logic [CW-1:0]            n_wr;
    logic                     ovf;
    logic                     accept;

    assign out_valid = full[rsel][rptr];
    assign out_r     = mem[rsel][rptr];
    assign out_row   = rptr;
    assign accept    = out_valid & out_ready;

    // A write only succeeds into an empty slot of its own bank; an accept on
    // the same row clears the other bank's bit, so the two never collide.
    always_comb begin
        wr_ok = '0;
        n_wr  = '0;
        ovf   = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (in_v[i]) begin
                if (!full[wsel[i]][i]) begin
                    wr_ok[i] = 1'b1;
                    n_wr     = n_wr + CW'(1);
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned i = 0; i < ROWS; i++)
                    mem[b][i] <= '0;
            full      <= '0;
            wsel      <= '0;
            rsel      <= 1'b0;
            rptr      <= '0;
            occupancy <= '0;
            err_ovf   <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                if (wr_ok[i]) begin
                    mem[wsel[i]][i]  <= in_r[i];
                    full[wsel[i]][i] <= 1'b1;
                    wsel[i]          <= ~wsel[i];
                end
            end
            tile_done <= 1'b0;
            if (accept) begin
                full[rsel][rptr] <= 1'b0;
                if (rptr == LAST) begin
                    rptr      <= '0;
                    rsel      <= ~rsel;
                    tile_done <= 1'b1;
                end else begin
                    rptr <= rptr + RW'(1);
                end
            end
            occupancy <= occupancy + n_wr - CW'(accept);
            if (ovf)
                err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_col_drain_buf.sv
// Directed bench for col_drain_buf (ROWS=8 and ROWS=5 instances) with an
// in-order scoreboard of {row, data} checked on every accept.
module tb_col_drain_buf;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] in_r8 [0:7];
    logic [7:0]  in_v8;
    logic [31:0] out_r8;
    logic        out_valid8, out_ready8, tile_done8, err_ovf8;
    logic [2:0]  out_row8;
    logic [4:0]  occ8;

    logic [31:0] in_r5 [0:4];
    logic [4:0]  in_v5;
    logic [31:0] out_r5;
    logic        out_valid5, out_ready5, tile_done5, err_ovf5;
    logic [2:0]  out_row5;
    logic [3:0]  occ5;

    logic [39:0] q8[$];
    logic [39:0] q5[$];
    int          td8 = 0;
    int          td5 = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    col_drain_buf #(.ROWS(8), .OUTWIDTH(32)) dut8 (
        .clk(clk), .rst(rst), .in_r(in_r8), .in_v(in_v8),
        .out_r(out_r8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_row(out_row8), .tile_done(tile_done8), .occupancy(occ8),
        .err_ovf(err_ovf8)
    );

    col_drain_buf #(.ROWS(5), .OUTWIDTH(32)) dut5 (
        .clk(clk), .rst(rst), .in_r(in_r5), .in_v(in_v5),
        .out_r(out_r5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_row(out_row5), .tile_done(tile_done5), .occupancy(occ5),
        .err_ovf(err_ovf5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every accepted word must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (tile_done8) td8++;
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) chk("spurious8", 64'(q8.size()), 64'd1);
                else chk("drain8", {8'(out_row8), out_r8}, q8.pop_front());
            end
            if (tile_done5) td5++;
            if (out_valid5 && out_ready5) begin
                if (q5.size() == 0) chk("spurious5", 64'(q5.size()), 64'd1);
                else chk("drain5", {8'(out_row5), out_r5}, q5.pop_front());
            end
        end
    end

    task automatic wr8(input logic [7:0] mask, input logic [31:0] base);
        for (int i = 0; i < 8; i++) in_r8[i] = base + 32'(i);
        in_v8 = mask;
        tick();
        in_v8 = '0;
    endtask

    task automatic push8(input logic [7:0] mask, input logic [31:0] base);
        for (int i = 0; i < 8; i++)
            if (mask[i]) q8.push_back({8'(i), base + 32'(i)});
    endtask

    task automatic wr5(input logic [4:0] mask, input logic [31:0] base);
        for (int i = 0; i < 5; i++) in_r5[i] = base + 32'(i);
        in_v5 = mask;
        tick();
        in_v5 = '0;
    endtask

    task automatic push5(input logic [4:0] mask, input logic [31:0] base);
        for (int i = 0; i < 5; i++)
            if (mask[i]) q5.push_back({8'(i), base + 32'(i)});
    endtask

    task automatic wait_drain(input int which);
        int budget = 60;
        while (((which == 8) ? q8.size() : q5.size()) != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_timeout", 64'((which == 8) ? q8.size() : q5.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_v8 = '0; in_v5 = '0;
        out_ready8 = 1'b0; out_ready5 = 1'b0;
        for (int i = 0; i < 8; i++) in_r8[i] = '0;
        for (int i = 0; i < 5; i++) in_r5[i] = '0;
        tick(); tick();
        chk("rst_valid", 64'(out_valid8), 64'd0);
        chk("rst_occ", 64'(occ8), 64'd0);
        chk("rst_row", 64'(out_row8), 64'd0);
        chk("rst_r", 64'(out_r8), 64'd0);
        rst = 1'b0;
        tick();

        // In-order drain
        wr8(8'hFF, 32'h100);
        chk("io_occ8", 64'(occ8), 64'd8);
        push8(8'hFF, 32'h100);
        out_ready8 = 1'b1;
        repeat (8) tick();
        chk("io_qempty", 64'(q8.size()), 64'd0);
        chk("io_tdone", 64'(tile_done8), 64'd1);
        chk("io_occ0", 64'(occ8), 64'd0);
        tick();
        chk("io_tdone_pulse", 64'(tile_done8), 64'd0);
        chk("io_tdcnt", 64'(td8), 64'd1);

        // Out-of-order fill: reader waits on its current row
        wr8(8'h08, 32'h200);
        chk("ooo_wait3", 64'(out_valid8), 64'd0);
        wr8(8'h02, 32'h200);
        chk("ooo_wait1", 64'(out_valid8), 64'd0);
        push8(8'h03, 32'h200);
        wr8(8'h01, 32'h200);
        chk("ooo_valid0", 64'(out_valid8), 64'd1);
        tick(); tick();
        chk("ooo_stall_valid", 64'(out_valid8), 64'd0);
        chk("ooo_stall_row", 64'(out_row8), 64'd2);
        chk("ooo_stall_occ", 64'(occ8), 64'd1);
        push8(8'h0C, 32'h200);
        wr8(8'h04, 32'h200);
        push8(8'hF0, 32'h200);
        wr8(8'hF0, 32'h200);
        wait_drain(8);
        chk("ooo_tdcnt", 64'(td8), 64'd2);

        // Double buffering and overflow
        out_ready8 = 1'b0;
        wr8(8'hFF, 32'h300);
        wr8(8'hFF, 32'h400);
        chk("db_occ16", 64'(occ8), 64'd16);
        chk("db_noovf", 64'(err_ovf8), 64'd0);
        wr8(8'h20, 32'hDEAD0000);
        chk("db_ovf", 64'(err_ovf8), 64'd1);
        chk("db_occ_hold", 64'(occ8), 64'd16);
        push8(8'hFF, 32'h300);
        push8(8'hFF, 32'h400);
        out_ready8 = 1'b1;
        wait_drain(8);
        chk("db_occ0", 64'(occ8), 64'd0);
        chk("db_ovf_sticky", 64'(err_ovf8), 64'd1);
        chk("db_tdcnt", 64'(td8), 64'd4);

        // Asynchronous reset mid-drain
        out_ready8 = 1'b0;
        wr8(8'hFF, 32'h500);
        push8(8'h07, 32'h500);
        out_ready8 = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid8), 64'd0);
        chk("ar_r", 64'(out_r8), 64'd0);
        chk("ar_row", 64'(out_row8), 64'd0);
        chk("ar_occ", 64'(occ8), 64'd0);
        chk("ar_ovf", 64'(err_ovf8), 64'd0);
        chk("ar_tdone", 64'(tile_done8), 64'd0);
        chk("ar_qempty", 64'(q8.size()), 64'd0);
        out_ready8 = 1'b0;
        tick();
        rst = 1'b0;
        q8.delete();
        td8 = 0;
        tick();
        chk("ar_post_valid", 64'(out_valid8), 64'd0);

        // Fresh tile, then simultaneous write and accept on row 4
        wr8(8'hFF, 32'h600);
        push8(8'hFF, 32'h600);
        out_ready8 = 1'b1;
        repeat (4) tick();
        chk("sw_row4", 64'(out_row8), 64'd4);
        chk("sw_occ_pre", 64'(occ8), 64'd4);
        wr8(8'h10, 32'h773);
        chk("sw_occ_post", 64'(occ8), 64'd4);
        chk("sw_noovf", 64'(err_ovf8), 64'd0);
        push8(8'h0F, 32'h800);
        push8(8'h10, 32'h773);
        push8(8'hE0, 32'h800);
        wr8(8'hEF, 32'h800);
        wait_drain(8);
        chk("sw_occ0", 64'(occ8), 64'd0);
        chk("sw_noovf_end", 64'(err_ovf8), 64'd0);
        chk("sw_tdcnt", 64'(td8), 64'd2);

        // Non-power-of-two wrap on the ROWS=5 instance
        wr5(5'h1F, 32'h900);
        wr5(5'h1F, 32'hA00);
        chk("np_occ10", 64'(occ5), 64'd10);
        wr5(5'h10, 32'hBAD0);
        chk("np_ovf", 64'(err_ovf5), 64'd1);
        push5(5'h1F, 32'h900);
        push5(5'h1F, 32'hA00);
        out_ready5 = 1'b1;
        wait_drain(5);
        chk("np_tdcnt", 64'(td5), 64'd2);
        chk("np_row_wrap", 64'(out_row5), 64'd0);
        chk("np_occ0", 64'(occ5), 64'd0);
        chk("np_valid0", 64'(out_valid5), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
